// File: rtl/dram_responder_if.sv
// Request/response bundle between the conv_layer and the DRAM responder.
// Error-report signals exist only when DRAM_ADDR_CHK_EN is defined.
interface dram_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
);
  logic                  en_wr;
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  en_rd;
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic                  valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic [31:0]           rd_cnt;
  logic [31:0]           wr_cnt;
`ifdef DRAM_ADDR_CHK_EN
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] err_addr;

  modport master (
    output en_wr, addr_wr, data_in, en_rd, addr_rd,
    input  valid, data_out, rd_cnt, wr_cnt, addr_err, err_addr
  );
  modport slave (
    input  en_wr, addr_wr, data_in, en_rd, addr_rd,
    output valid, data_out, rd_cnt, wr_cnt, addr_err, err_addr
  );
`else
  modport master (
    output en_wr, addr_wr, data_in, en_rd, addr_rd,
    input  valid, data_out, rd_cnt, wr_cnt
  );
  modport slave (
    input  en_wr, addr_wr, data_in, en_rd, addr_rd,
    output valid, data_out, rd_cnt, wr_cnt
  );
`endif
endinterface

// File: rtl/dram_responder.sv
// Fixed-latency DRAM responder with write-first forwarding and counters.
// Optional DRAM_ADDR_CHK_EN adds sticky out-of-range error reporting.
module dram_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int MEM_DEPTH  = 65536,
  parameter int RD_LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  dram_responder_if.slave bus
);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  wr_ok;
  logic                  rd_ok;
  logic                  fwd;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;

  assign wr_ok  = {1'b0, bus.addr_wr} < DEPTH;
  assign rd_ok  = {1'b0, bus.addr_rd} < DEPTH;
  assign wr_idx = bus.addr_wr[IW-1:0];
  assign rd_idx = bus.addr_rd[IW-1:0];
  assign fwd    = bus.en_wr && wr_ok
               && (bus.addr_wr == bus.addr_rd);

  // Same-edge write wins over the array read.
  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      !rd_ok:  rd_word = '0;
      fwd:     rd_word = bus.data_in;
      default: rd_word = mem[rd_idx];
    endcase
  end

  always_ff @(posedge clk) begin
    if (bus.en_wr && wr_ok)
      mem[wr_idx] <= bus.data_in;
  end

  logic [RD_LATENCY-1:0] vld;
  logic [DATA_WIDTH-1:0] dat [RD_LATENCY];

  // Data stages load only with a live word, so data_out holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < RD_LATENCY; k++)
        dat[k] <= '0;
    end else begin
      vld[0] <= bus.en_rd;
      if (bus.en_rd)
        dat[0] <= rd_word;
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1])
          dat[k] <= dat[k-1];
      end
    end
  end

  assign bus.valid    = vld[RD_LATENCY-1];
  assign bus.data_out = dat[RD_LATENCY-1];

  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (bus.en_rd)
        rd_cnt <= rd_cnt + 32'd1;
      if (bus.en_wr)
        wr_cnt <= wr_cnt + 32'd1;
    end
  end

  assign bus.rd_cnt = rd_cnt;
  assign bus.wr_cnt = wr_cnt;

`ifdef DRAM_ADDR_CHK_EN
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] err_addr;
  logic                  bad_rd;
  logic                  bad_wr;

  assign bad_rd = bus.en_rd && !rd_ok;
  assign bad_wr = bus.en_wr && !wr_ok;

  // Only the first offending address is kept; reads win ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err <= 1'b0;
      err_addr <= '0;
    end else if (!addr_err && (bad_rd || bad_wr)) begin
      addr_err <= 1'b1;
      err_addr <= bad_rd ? bus.addr_rd : bus.addr_wr;
    end
  end

  assign bus.addr_err = addr_err;
  assign bus.err_addr = err_addr;
`endif
endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Synthesizable responder end of the conv-layer DRAM interface: accepts the write strobes and read requests the conv_layer issues (en_wr/addr_wr/data_in, en_rd/addr_rd).
- Returns read data with a fixed, parameterized latency, qualified by a one-cycle valid pulse.
- Drop-in replacement for the behavioural DRAM model in layer-level benches and FPGA bring-up.
- Keeps read/write transaction counters for bandwidth checks.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 18, address width.
- MEM_DEPTH, 65536, number of implemented words; legal addresses are 0..MEM_DEPTH-1.
- RD_LATENCY, 2, cycles from request edge to valid data; legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en_wr  in  1  write strobe, one word per cycle.
- addr_wr  in  ADDR_WIDTH  write address.
- data_in  in  DATA_WIDTH  write data.
- en_rd  in  1  read request strobe, one request per cycle.
- addr_rd  in  ADDR_WIDTH  read address.
- valid  out  1  data_out qualifier, one-cycle pulse per read.
- data_out  out  DATA_WIDTH  read data.
- rd_cnt  out  32  reads accepted since reset.
- wr_cnt  out  32  writes accepted since reset.

Behaviour:
- Reset (async, active-high):
  - valid=0, data_out=0, rd_cnt=0, wr_cnt=0.
  - Latency pipeline valid bits cleared; in-flight reads are dropped, never returned.
  - Memory contents are not cleared.
  - Deassertion is sampled normally; the first request is accepted at the first rising edge after rst falls.
- No handshake or backpressure:
  - Responder is always ready; every en_rd/en_wr edge is accepted.
  - Back-to-back reads every cycle are legal; throughput is 1 read + 1 write per cycle.
- Write: en_wr=1 at edge N writes data_in to mem[addr_wr] at edge N. wr_cnt increments by 1.
- Read:
  - en_rd=1 at edge N samples mem[addr_rd] into pipeline stage 0. rd_cnt increments by 1.
  - The word shifts through RD_LATENCY-1 further register stages.
  - valid=1 and data_out=word for exactly the cycle following edge N+RD_LATENCY-1.
  - RD_LATENCY=1: valid in the cycle right after the request edge.
- Response ordering:
  - Responses return in request order, one per request, with no gaps inserted.
  - When valid=0, data_out holds its last value and is don't-care to consumers.
- Same-cycle read and write to the same address: write-first. The read returns data_in of that cycle (forwarded).
- Read of an address written on an earlier edge returns the new data.
- Out-of-range address (>= MEM_DEPTH):
  - Write is ignored; wr_cnt still increments.
  - Read returns 0 with normal valid timing; rd_cnt still increments.
- Counters wrap modulo 2^32 with no saturation.
- Pipeline implementation: shift register of {valid bit, data word}, depth RD_LATENCY. Output stage drives valid/data_out directly from flops, with no combinational path from inputs.

Optional Feature:
- Macro: DRAM_ADDR_CHK_EN.
- Defined:
  - Adds output port addr_err (1 bit, reset 0).
  - addr_err sets sticky to 1 on the edge that accepts any out-of-range read or write; it clears only on rst.
  - Adds output port err_addr (ADDR_WIDTH, reset 0), which captures the first offending address (read has priority if both are out of range on the same edge).
- Undefined: neither port exists. Out-of-range accesses are handled silently as above.

Test Plan:
- Reset/idle: hold rst 3 cycles, then idle 10 cycles -> valid=0, data_out=0, rd_cnt=0, wr_cnt=0 throughout.
- Write then streaming read (RD_LATENCY=2):
  - Stimulus: write 0x11111111..0x44444444 to addr 0..3, then en_rd for 4 consecutive cycles at addr 0..3.
  - Response: valid high 4 consecutive cycles starting 2 cycles after the first request edge, data in order; rd_cnt=4, wr_cnt=4.
- Write-first collision: same edge en_wr addr 5 data 0xDEADBEEF and en_rd addr 5 (old value 0) -> returned word 0xDEADBEEF.
- Reset mid-flight: issue reads at addr 0,1 with RD_LATENCY=3, assert rst one cycle later -> no valid pulse ever appears for either request; counters read 0.
- Out-of-range:
  - Stimulus: with MEM_DEPTH=65536, write 0xA5A5A5A5 to 0x10000, then read 0x10000 and 0x00000.
  - Response: first read returns 0; mem[0] unchanged; with DRAM_ADDR_CHK_EN, addr_err=1 and err_addr=0x10000.
- Latency sweep: RD_LATENCY=1 and 8, single read -> valid exactly 1 and 8 cycles after the request edge respectively, single-cycle pulse.
